// File: rtl/xphm_pp_pkg.sv
// Shared types and default sizes for the ping-pong X packet heads memory.
package xphm_pp_pkg;

  localparam int XPHM_DATA_WIDTH    = 64;
  localparam int XPHM_DEPTH         = 16;
  localparam int XPHM_NUM_PIPE      = 2;
  localparam int XPHM_PP_NRD        = 2;
  localparam int DDR_AXI_ADDR_WIDTH = 32;
  localparam int DDR_LEN_WIDTH      = 32;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_CHK  = 3'd1,
    LD_DESC = 3'd2,
    LD_RECV = 3'd3,
    LD_DONE = 3'd4
  } ld_state_e;

  // ceil(n / 2**l2), kept 33 bits wide so n near 2**32 cannot wrap
  function automatic logic [32:0] n_entries(
    input logic [31:0] n,
    input int          l2
  );
    return ({1'b0, n} + 33'((1 << l2) - 1)) >> l2;
  endfunction

endpackage

// File: rtl/xphm_pp_bank.sv
// One bank replica: 1W/1R RAM with a registered read and NUM_PIPE
// output stages that only advance behind a valid read.
module xphm_pp_bank
  import xphm_pp_pkg::*;
#(
  parameter int DATA_W   = XPHM_DATA_WIDTH,
  parameter int DEPTH    = XPHM_DEPTH,
  parameter int NUM_PIPE = XPHM_NUM_PIPE,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dat_q [NUM_PIPE+1];
  logic [DATA_W-1:0] dat_d [NUM_PIPE+1];
  logic [NUM_PIPE:0] v_q, v_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k <= NUM_PIPE; k++) dat_d[k] = dat_q[k];
    v_d[0] = re;
    if (re) dat_d[0] = mem[raddr];
    for (int k = 1; k <= NUM_PIPE; k++) begin
      v_d[k] = v_q[k-1];
      if (v_q[k-1]) dat_d[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q <= '0;
      for (int k = 0; k <= NUM_PIPE; k++) dat_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k <= NUM_PIPE; k++) dat_q[k] <= dat_d[k];
    end
  end

  assign rdata = dat_q[NUM_PIPE];

endmodule

// File: rtl/xphm_pp.sv
// Double-buffered X packet heads memory: DMA loads the shadow bank
// while NRD ports read the active bank; a host swap exchanges them.
module xphm_pp
  import xphm_pp_pkg::*;
#(
  parameter int DATA_W   = XPHM_DATA_WIDTH,
  parameter int DEPTH    = XPHM_DEPTH,
  parameter int NRD      = XPHM_PP_NRD,
  parameter int NUM_PIPE = XPHM_NUM_PIPE,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          hc_d2c_start_pulse,
  input  logic [31:0]                   hc_d2c_d_addr,
  input  logic [31:0]                   hc_d2c_c_addr,
  input  logic [31:0]                   hc_d2c_n_bytes,
  output logic                          hc_d2c_done_pulse,
  output logic                          hc_d2c_err,
  input  logic                          hc_swap_pulse,
  output logic                          hc_busy,
  output logic                          active_bank,
  output logic [DDR_AXI_ADDR_WIDTH-1:0] dma_rd_desc_addr,
  output logic [DDR_LEN_WIDTH-1:0]      dma_rd_desc_len,
  output logic                          dma_rd_desc_valid,
  input  logic [DATA_W-1:0]             dma_rd_read_data_tdata,
  input  logic                          dma_rd_read_data_tvalid,
  input  logic                          dma_rd_read_data_tlast,
  input  logic [NRD-1:0]                rd_en,
  input  logic [NRD-1:0]                rd_last,
  input  logic [NRD*AW-1:0]             rd_addr,
  output logic [NRD*DATA_W-1:0]         dout,
  output logic [NRD-1:0]                dout_vld,
  output logic [NRD-1:0]                dout_last
);

  localparam int BL2 = $clog2(DATA_W / 8);

  ld_state_e     state_q, state_d;
  logic [31:0]   d_addr_q, d_addr_d;
  logic [31:0]   c_addr_q, c_addr_d;
  logic [31:0]   n_bytes_q, n_bytes_d;
  logic [32:0]   nent_q, nent_d;
  logic [32:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          err_q, err_d;
  logic          act_q, act_d;
  logic          swp_q, swp_d;
  logic          wr_en;
  logic [33:0]   end_idx;

  always_comb begin
    state_d   = state_q;
    d_addr_d  = d_addr_q;
    c_addr_d  = c_addr_q;
    n_bytes_d = n_bytes_q;
    nent_d    = nent_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    err_d     = err_q;
    act_d     = act_q;
    swp_d     = swp_q | hc_swap_pulse;
    wr_en     = 1'b0;
    end_idx   = {2'b0, c_addr_q} + {1'b0, nent_q};
    unique case (state_q)
      LD_IDLE: begin
        // swap first so a same-cycle start targets the new shadow
        if (swp_q) begin
          act_d = ~act_q;
          swp_d = hc_swap_pulse;
        end
        if (hc_d2c_start_pulse) begin
          d_addr_d  = hc_d2c_d_addr;
          c_addr_d  = hc_d2c_c_addr;
          n_bytes_d = hc_d2c_n_bytes;
          nent_d    = n_entries(hc_d2c_n_bytes, BL2);
          state_d   = LD_CHK;
        end
      end
      LD_CHK: begin
        if (nent_q == '0 || end_idx > 34'(DEPTH)) begin
          err_d   = 1'b1;
          state_d = LD_DONE;
        end else begin
          err_d    = 1'b0;
          wr_ptr_d = c_addr_q[AW-1:0];
          cnt_d    = '0;
          state_d  = LD_DESC;
        end
      end
      LD_DESC: state_d = LD_RECV;
      LD_RECV: begin
        if (dma_rd_read_data_tvalid) begin
          if (cnt_q < nent_q) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + 33'd1;
          end
          if (dma_rd_read_data_tlast || cnt_d == nent_q)
            state_d = LD_DONE;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LD_IDLE;
      d_addr_q  <= '0;
      c_addr_q  <= '0;
      n_bytes_q <= '0;
      nent_q    <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      err_q     <= 1'b0;
      act_q     <= 1'b0;
      swp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_addr_q  <= d_addr_d;
      c_addr_q  <= c_addr_d;
      n_bytes_q <= n_bytes_d;
      nent_q    <= nent_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      err_q     <= err_d;
      act_q     <= act_d;
      swp_q     <= swp_d;
    end
  end

  assign hc_busy           = (state_q != LD_IDLE) | swp_q;
  assign hc_d2c_done_pulse = (state_q == LD_DONE);
  assign hc_d2c_err        = err_q;
  assign active_bank       = act_q;
  assign dma_rd_desc_valid = (state_q == LD_DESC);
  assign dma_rd_desc_addr  =
    dma_rd_desc_valid ? DDR_AXI_ADDR_WIDTH'(d_addr_q) : '0;
  assign dma_rd_desc_len   =
    dma_rd_desc_valid ? DDR_LEN_WIDTH'(n_bytes_q) : '0;

  // per-port {vld, last, bank} pipeline; bank only advances with vld
  logic [NRD-1:0][NUM_PIPE:0] pv_q, pv_d, pl_q, pl_d, pb_q, pb_d;

  always_comb begin
    pv_d = pv_q;
    pl_d = pl_q;
    pb_d = pb_q;
    for (int p = 0; p < NRD; p++) begin
      pv_d[p][0] = rd_en[p];
      pl_d[p][0] = rd_last[p];
      if (rd_en[p]) pb_d[p][0] = act_q;
      for (int k = 1; k <= NUM_PIPE; k++) begin
        pv_d[p][k] = pv_q[p][k-1];
        pl_d[p][k] = pl_q[p][k-1];
        if (pv_q[p][k-1]) pb_d[p][k] = pb_q[p][k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q <= '0;
      pl_q <= '0;
      pb_q <= '0;
    end else begin
      pv_q <= pv_d;
      pl_q <= pl_d;
      pb_q <= pb_d;
    end
  end

  logic [DATA_W-1:0] bank_rd [2][NRD];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BID = 1'(b);
    for (genvar p = 0; p < NRD; p++) begin : g_port
      xphm_pp_bank #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NUM_PIPE(NUM_PIPE),
        .AW      (AW)
      ) u_bank (
        .clk  (clk),
        .rstn (rstn),
        .we   (wr_en & (act_q != BID)),
        .waddr(wr_ptr_q),
        .wdata(dma_rd_read_data_tdata),
        .re   (rd_en[p] & (act_q == BID)),
        .raddr(rd_addr[p*AW +: AW]),
        .rdata(bank_rd[b][p])
      );
    end
  end

  always_comb begin
    dout      = '0;
    dout_vld  = '0;
    dout_last = '0;
    for (int p = 0; p < NRD; p++) begin
      dout[p*DATA_W +: DATA_W] = bank_rd[pb_q[p][NUM_PIPE]][p];
      dout_vld[p]  = pv_q[p][NUM_PIPE];
      dout_last[p] = pl_q[p][NUM_PIPE];
    end
  end

endmodule
